uart_rx_byte_stream: RTL
========================

// Module: uart_rx_byte_stream
// PURPOSE
//  - UART receiver front-end for high_throughput_test_harness. Deserialises the host's
//    uart_receive line (8N1, LSB first) into bytes.
//  - Buffers received bytes in a small FIFO and presents them on a valid/ready stream
//    to the harness core.
//  - Flags framing errors and FIFO overflows as single-cycle pulses.
// PARAMETERS
//  - CLOCK_FREQUENCY  100_000_000  system clock in Hz
//  - BAUD_RATE        115_200      line rate in baud
//  - FIFO_DEPTH       4            byte buffer entries; power of two, >= 2
//  - Local CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE (integer divide, must be >= 4);
//    HALF_BIT = CYCLES_PER_BIT / 2
// PORTS
//  - clock           in   1                       system clock, rising edge
//  - reset           in   1                       asynchronous, active-high
//  - uart_receive    in   1                       serial line from host, idle high, asynchronous to clock
//  - data_out        out  8                       head-of-FIFO byte
//  - data_out_valid  out  1                       FIFO not empty
//  - data_out_ready  in   1                       consumer accepts data_out when valid && ready
//  - framing_error   out  1                       1-cycle pulse: stop bit sampled low
//  - overflow        out  1                       1-cycle pulse: byte dropped, FIFO full
//  - fifo_count      out  $clog2(FIFO_DEPTH)+1    bytes currently buffered
// BEHAVIOUR
//  - Reset values: data_out=0, data_out_valid=0, framing_error=0, overflow=0,
//    fifo_count=0. FIFO empty, FSM IDLE. Synchroniser flops reset to 1.
//  - Reset mid-frame aborts the frame with no output.
//  - Input path: uart_receive goes through a 2-flop synchroniser (rx_s). All FSM
//    decisions use rx_s.
//  - Bit timer counts down. "Sample" means the cycle the timer reaches 0.
//  - FSM IDLE: when rx_s==0, load HALF_BIT-1 and go to START.
//  - FSM START: at sample, rx_s==1 is a glitch: go to IDLE, no pulse. Otherwise load
//    CYCLES_PER_BIT-1, clear the bit index and go to DATA.
//  - FSM DATA: at each sample, shift rx_s into shift[bit_index] (LSB first) and reload
//    CYCLES_PER_BIT-1. After bit 7 go to STOP.
//  - FSM STOP: at sample, rx_s==1 pushes shift into the FIFO and goes to IDLE; the
//    second half of the stop bit is not waited out, so back-to-back frames resync.
//    rx_s==0 pulses framing_error, discards the byte and goes to BREAK.
//  - FSM BREAK: wait for rx_s==1, then go to IDLE. No bytes and no further error pulses
//    while the line is held low.
//  - Latency: a pushed byte appears on data_out with data_out_valid=1 on the cycle
//    after the stop sample.
//  - FIFO: first-word fall-through. data_out_valid = (fifo_count != 0). Pop on
//    data_out_valid && data_out_ready. Pointers wrap modulo FIFO_DEPTH.
//  - Push while full, no pop: byte dropped, overflow pulses 1 cycle, contents unchanged.
//  - Push while full with a pop in the same cycle: push accepted, count unchanged, no
//    overflow.
//  - Push and pop together when not full: count unchanged.
//  - Pop when empty: ignored.
//  - data_out holds steady while valid && !ready.
// STRUCTURE
//  - Shared package uart_pkg: rx_state_t enum {IDLE, START, DATA, STOP, BREAK},
//    UART_DATA_BITS=8, and a cycles_per_bit() constant function shared with the UART
//    transmitter.
//  - One sub-module, byte_fifo (DEPTH, WIDTH=8): push/pop, FWFT head, count, full,
//    empty. It is reused by the transmit side.
//  - The FSM, bit timer and synchroniser live in this top module.
// TESTING (CLOCK_FREQUENCY=100, BAUD_RATE=10, so 10 cycles/bit; FIFO_DEPTH=4)
//  - Stream: data_out_ready=1, send 0x11,0x22,0x33,0x44. Expect 4 pops in order, each
//    valid 1 cycle after its stop sample, and no error or overflow pulses.
//  - Overflow: data_out_ready=0, send 0x11,0x22,0x33,0x44,0x01. Expect fifo_count=4 and
//    exactly one overflow pulse on the 5th byte. Set ready=1: drains 0x11,0x22,0x33,0x44,
//    then valid=0.
//  - Glitch: hold uart_receive low for 3 cycles, then high. Expect no byte,
//    framing_error=0, FSM back in IDLE. A following 0x5A is received correctly.
//  - Framing/break: send 0x55 with stop bit 0, hold the line low 20 bit times, then high,
//    then send 0xA5. Expect exactly one framing_error pulse, no 0x55, then 0xA5 delivered.
//  - Reset mid-frame: assert reset during data bit 4 of 0x0F. Expect all outputs 0
//    immediately (async). After release, 0x01 is received as the only byte.
//  - Full plus simultaneous pop: fill the FIFO, then assert ready for 1 cycle exactly on
//    the 5th byte's push cycle. Expect the push accepted, fifo_count stays 4, no
//    overflow, and byte order preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter types, constants and baud timing helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  localparam int UART_DATA_BITS = 8;
  function automatic int cycles_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: first-word fall-through buffer with occupancy count
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic pop_ok, push_ok;
  // a pop frees the slot that a same-cycle push into a full buffer needs
  always_comb begin
    empty = count == '0;
    full = count == (AW+1)'(DEPTH);
    pop_ok = pop && !empty;
    push_ok = push && (!full || pop_ok);
    head = mem[rd_ptr];
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop_ok);
      wr_ptr <= wr_ptr + AW'(push_ok);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  // storage is cleared so the head reads zero out of reset
  always_ff @(posedge clock or posedge reset)
    if (reset)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (push_ok)
      mem[wr_ptr] <= data_in;
endmodule

// File: rtl/uart_rx_byte_stream.sv
// uart_rx_byte_stream: 8N1 UART receiver feeding a byte FIFO on a valid/ready stream
module uart_rx_byte_stream
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            uart_receive,
  output logic [UART_DATA_BITS-1:0]       data_out,
  output logic                            data_out_valid,
  input  logic                            data_out_ready,
  output logic                            framing_error,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
  localparam int CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF_BIT = CYCLES_PER_BIT / 2;
  localparam int TW = $clog2(CYCLES_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  logic rx_meta, rx_s;
  rx_state_t state, next_state;
  logic [TW-1:0] timer;
  logic [BW-1:0] bit_index;
  logic [UART_DATA_BITS-1:0] shift;
  logic tick, push, stop_err, full, empty, pop;
  assign data_out_valid = !empty;
  assign pop = data_out_valid && data_out_ready;
  // two-flop synchroniser, idle-high out of reset so no false start bit
  always_ff @(posedge clock or posedge reset)
    if (reset) {rx_meta, rx_s} <= 2'b11;
    else {rx_meta, rx_s} <= {uart_receive, rx_meta};
  // FSM state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  // FSM transitions; stop sample returns to IDLE at mid-bit so back-to-back frames resync
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = rx_s ? IDLE : START;
      START:   next_state = !tick ? START : rx_s ? IDLE : DATA;
      DATA:    next_state = tick && bit_index == BW'(UART_DATA_BITS - 1) ? STOP : DATA;
      STOP:    next_state = !tick ? STOP : rx_s ? IDLE : BREAK;
      BREAK:   next_state = rx_s ? IDLE : BREAK;
      default: next_state = IDLE;
    endcase
  end
  // FSM outputs: mid-bit sample strobe, byte push and stop-bit error
  always_comb begin
    tick = timer == '0;
    push = state == STOP && tick && rx_s;
    stop_err = state == STOP && tick && !rx_s;
  end
  // bit timer counts down to each mid-bit sample; data bits shift in LSB first
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      timer <= '0;
      bit_index <= '0;
      shift <= '0;
    end else begin
      timer <= state == IDLE ? TW'(HALF_BIT - 1) : tick ? TW'(CYCLES_PER_BIT - 1) : timer - TW'(1);
      bit_index <= state == DATA ? bit_index + BW'(tick) : '0;
      if (state == DATA && tick) shift[bit_index] <= rx_s;
    end
  // single-cycle error pulses, registered alongside the FIFO update
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      framing_error <= 1'b0;
      overflow <= 1'b0;
    end else begin
      framing_error <= stop_err;
      overflow <= push && full && !pop;
    end
  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .data_in(shift),
    .head   (data_out),
    .count  (fifo_count),
    .full   (full),
    .empty  (empty)
  );
endmodule
